// File: rtl/abs_modulator_ctrl_if.sv
// Brake request, speed inputs and valve/status outputs of the ABS modulator.
// master = ABS controller side, slave = modulator.
interface abs_modulator_ctrl_if;
    localparam int unsigned SPEED_W = 8;
    localparam int unsigned CNT_W   = 8;

    logic               brake_req;
    logic [SPEED_W-1:0] wheel_speed;
    logic [SPEED_W-1:0] vehicle_speed;
    logic               valve_apply;
    logic               valve_release;
    logic               abs_active;
    logic [CNT_W-1:0]   cycle_cnt;
    logic               abs_fault;

    modport master (
        output brake_req, wheel_speed, vehicle_speed,
        input  valve_apply, valve_release, abs_active, cycle_cnt, abs_fault
    );

    modport slave (
        input  brake_req, wheel_speed, vehicle_speed,
        output valve_apply, valve_release, abs_active, cycle_cnt, abs_fault
    );
endinterface

// File: rtl/abs_modulator_ctrl.sv
// ABS valve sequencer: APPLY/RELEASE/HOLD pulses limiting wheel slip while braking.
// Optional release-timeout watchdog enabled by defining ABS_WATCHDOG_EN.
module abs_modulator_ctrl #(
`ifdef ABS_WATCHDOG_EN
    parameter int unsigned FAULT_LIMIT = 3,
`endif
    parameter int unsigned SLIP_HI     = 16,
    parameter int unsigned SLIP_LO     = 6,
    parameter int unsigned MIN_SPEED   = 10,
    parameter int unsigned RELEASE_MAX = 20,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    abs_modulator_ctrl_if.slave  bus
);
    localparam int unsigned SPEED_W = 8;
    localparam int unsigned TMR_W   = 8;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   timer;
    logic [SPEED_W-1:0] slip_c;
    logic               enter_rel_c;
    logic               rel_slip_exit_c;
    logic               rel_timeout_c;
    logic               fault;

    // Slip clamps to zero when the wheel is not slower than the vehicle
    assign slip_c = (bus.wheel_speed >= bus.vehicle_speed) ? '0
                  : SPEED_W'(bus.vehicle_speed - bus.wheel_speed);

    always_comb begin
        state_nxt       = state;
        enter_rel_c     = 1'b0;
        rel_slip_exit_c = 1'b0;
        rel_timeout_c   = 1'b0;
        if (!bus.brake_req) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: state_nxt = ST_APPLY;
                ST_APPLY: begin
                    if (slip_c > SPEED_W'(SLIP_HI) &&
                        bus.vehicle_speed >= SPEED_W'(MIN_SPEED) && !fault) begin
                        state_nxt   = ST_RELEASE;
                        enter_rel_c = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Slip recovery wins over a coincident timeout
                    if (slip_c <= SPEED_W'(SLIP_LO)) begin
                        state_nxt       = ST_HOLD;
                        rel_slip_exit_c = 1'b1;
                    end else if (timer == TMR_W'(RELEASE_MAX - 1)) begin
                        state_nxt     = ST_HOLD;
                        rel_timeout_c = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (timer == TMR_W'(HOLD_CYCLES - 1)) state_nxt = ST_APPLY;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, phase timer and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            timer             <= '0;
            bus.valve_apply   <= 1'b0;
            bus.valve_release <= 1'b0;
            bus.abs_active    <= 1'b0;
            bus.cycle_cnt     <= '0;
        end else begin
            state             <= state_nxt;
            timer             <= (state_nxt != state) ? '0 : TMR_W'(timer + TMR_W'(1));
            bus.valve_apply   <= (state_nxt == ST_APPLY);
            bus.valve_release <= (state_nxt == ST_RELEASE);
            if (state_nxt == ST_IDLE) begin
                bus.abs_active <= 1'b0;
                bus.cycle_cnt  <= '0;
            end else if (enter_rel_c) begin
                bus.abs_active <= 1'b1;
                if (bus.cycle_cnt != {CNT_W{1'b1}})
                    bus.cycle_cnt <= CNT_W'(bus.cycle_cnt + CNT_W'(1));
            end
        end
    end

`ifdef ABS_WATCHDOG_EN
    localparam int unsigned FCNT_W = $clog2(FAULT_LIMIT + 1);

    logic [FCNT_W-1:0] fault_cnt;

    // Consecutive release timeouts; sticky fault once the limit is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            if (fault_cnt >= FCNT_W'(FAULT_LIMIT)) fault <= 1'b1;
            if (rel_slip_exit_c)
                fault_cnt <= '0;
            else if (rel_timeout_c && fault_cnt < FCNT_W'(FAULT_LIMIT))
                fault_cnt <= FCNT_W'(fault_cnt + FCNT_W'(1));
        end
    end
`else
    assign fault = 1'b0;
`endif

    assign bus.abs_fault = fault;

endmodule

// File: tb/tb_abs_modulator_ctrl.sv
// Scoreboard bench for abs_modulator_ctrl: a cycle model predicts outputs per driven cycle.
module tb_abs_modulator_ctrl;
    localparam int SLIP_HI = 16, SLIP_LO = 6, MIN_SPEED = 10;
    localparam int RELEASE_MAX = 20, HOLD_CYCLES = 4, FAULT_LIMIT = 3;
`ifdef ABS_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    abs_modulator_ctrl_if bus ();
    abs_modulator_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic       apply;
        logic       rel;
        logic       active;
        logic [7:0] cnt;
        logic       fault;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: 0 idle, 1 apply, 2 release, 3 hold
    int m_st, m_tmr, m_cnt, m_fcnt;
    bit m_act, m_fault;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_cnt = 0; m_fcnt = 0; m_act = 0; m_fault = 0;
    endtask

    task automatic model_step(input bit br, input int ws, input int vs);
        int slip, ns;
        bit nfault;
        slip   = (ws >= vs) ? 0 : vs - ws;
        ns     = m_st;
        nfault = m_fault;
        if (WDOG && m_fcnt >= FAULT_LIMIT) nfault = 1;
        if (!br) ns = 0;
        else if (m_st == 0) ns = 1;
        else if (m_st == 1) begin
            if (slip > SLIP_HI && vs >= MIN_SPEED && !m_fault) ns = 2;
        end else if (m_st == 2) begin
            if (slip <= SLIP_LO) begin
                ns = 3;
                m_fcnt = 0;
            end else if (m_tmr == RELEASE_MAX - 1) begin
                ns = 3;
                if (m_fcnt < FAULT_LIMIT) m_fcnt++;
            end
        end else if (m_tmr == HOLD_CYCLES - 1) ns = 1;
        if (ns == 0) begin
            m_act = 0; m_cnt = 0;
        end else if (m_st == 1 && ns == 2) begin
            m_act = 1;
            if (m_cnt < 255) m_cnt++;
        end
        m_tmr   = (ns != m_st) ? 0 : m_tmr + 1;
        m_st    = ns;
        m_fault = nfault;
    endtask

    task automatic push_expected();
        exp_t e;
        e.apply  = (m_st == 1);
        e.rel    = (m_st == 2);
        e.active = m_act;
        e.cnt    = 8'(m_cnt);
        e.fault  = m_fault;
        sb_q.push_back(e);
    endtask

    task automatic pop_compare(input string where);
        exp_t e;
        check_eq({where, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq({where, "_apply"},   32'(bus.valve_apply),   32'(e.apply));
            check_eq({where, "_release"}, 32'(bus.valve_release), 32'(e.rel));
            check_eq({where, "_active"},  32'(bus.abs_active),    32'(e.active));
            check_eq({where, "_cnt"},     32'(bus.cycle_cnt),     32'(e.cnt));
            check_eq({where, "_fault"},   32'(bus.abs_fault),     32'(e.fault));
        end
    endtask

    // One clock cycle of stimulus; outputs checked 1 time unit after the edge
    task automatic drive(input string where, input bit br, input int ws, input int vs);
        bus.brake_req     = br;
        bus.wheel_speed   = 8'(ws);
        bus.vehicle_speed = 8'(vs);
        model_step(br, ws, vs);
        push_expected();
        @(posedge clk);
        #1;
        pop_compare(where);
    endtask

    initial begin
        int hold_len, run, first_run;
        bit seen_apply;
        rst_n = 1'b0;
        bus.brake_req = 1'b0;
        bus.wheel_speed = '0;
        bus.vehicle_speed = '0;
        model_reset();
        #12;
        push_expected();
        pop_compare("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: plain apply, small slip
        repeat (3) drive("t1", 1, 95, 100);

        // T2: slip 20 releases, recovery holds exactly HOLD_CYCLES
        drive("t2_rel", 1, 80, 100);
        hold_len = 0; seen_apply = 0;
        for (int i = 0; i < 8; i++) begin
            drive("t2_hold", 1, 96, 100);
            if (bus.valve_apply) seen_apply = 1;
            else if (!seen_apply && !bus.valve_release) hold_len++;
        end
        check_eq("t2_hold_len", 32'(hold_len), 32'(HOLD_CYCLES));

        // T3: constant slip 20 -> release times out after RELEASE_MAX cycles
        run = 0; first_run = 0;
        for (int i = 0; i < 50; i++) begin
            drive("t3", 1, 80, 100);
            if (bus.valve_release) run++;
            else if (run > 0 && first_run == 0) first_run = run;
        end
        check_eq("t3_release_len", 32'(first_run), 32'(RELEASE_MAX));

        // T5: brake release mid-RELEASE returns to idle
        repeat (3) drive("t5_rel", 1, 80, 100);
        drive("t5_drop", 0, 80, 100);

        // T4: below MIN_SPEED no modulation
        repeat (10) drive("t4", 1, 0, 8);
        check_eq("t4_apply_held", 32'(bus.valve_apply), 32'd1);
        check_eq("t4_not_active", 32'(bus.abs_active), 32'd0);

        // Speed dropping below MIN_SPEED mid-release does not abort it
        bus.brake_req = 1'b1;
        drive("lowv_enter", 1, 80, 100);
        repeat (5) drive("lowv_rel", 1, 0, 8);
        check_eq("lowv_still_release", 32'(bus.valve_release), 32'd1);
        repeat (3) drive("lowv_hold", 1, 100, 100);

        // Async reset mid-HOLD, no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_expected();
        pop_compare("async_rst");
        check_eq("async_rst_apply", 32'(bus.valve_apply), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T6: constant slip 30 -> repeated timeouts (fault only with watchdog)
        repeat (80) drive("t6", 1, 70, 100);
        check_eq("t6_fault_end", 32'(bus.abs_fault), 32'(WDOG));
        check_eq("t6_plain_apply", 32'(bus.valve_apply), 32'(WDOG));
        repeat (3) drive("t6_idle", 0, 70, 100);

        // Randomised episodes with held input chunks
        for (int k = 0; k < 60; k++) begin
            int v, s, w, len;
            bit br;
            v   = $urandom_range(0, 120);
            s   = $urandom_range(0, 25);
            w   = (s > v) ? 0 : v - s;
            if ($urandom_range(0, 7) == 0) w = $urandom_range(0, 255);
            br  = ($urandom_range(0, 11) != 0);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) drive("rand", br, w, v);
        end

        // Reset is the only thing that clears a fault
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_expected();
        pop_compare("final_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst", 1, 95, 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
